// File: rtl/d_reg.sv
// D-type storage register with load enable, synchronous active-low clear,
// and true/complement outputs. The complement is derived from the same flop.
module d_reg #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [63:0]      RESET_VALUE = '0
) (
    input  logic             MainClock,
    input  logic             MainReset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load qualification lives in the data path, never on the clock.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge MainClock) begin
        if (!MainReset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: tb/tb_d_reg.sv
// Scoreboard bench for d_reg: a 4-bit/reset-0 and an 8-bit/reset-5A instance
// share stimulus; expectations are queued per edge and checked by a monitor.
module tb_d_reg;

    typedef struct {
        logic [3:0] e4;
        logic [7:0] e8;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld;
    logic [7:0] dv;
    logic [3:0] q4;
    logic [3:0] qn4;
    logic [7:0] q8;
    logic [7:0] qn8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur;
    logic [3:0] m4;
    logic [7:0] m8;

    always #5 clk = ~clk;

    d_reg #(.WIDTH(4), .RESET_VALUE(64'h0)) u_d4 (
        .MainClock (clk),
        .MainReset (rst_n),
        .load      (ld),
        .d         (dv[3:0]),
        .q         (q4),
        .qn        (qn4)
    );

    d_reg #(.WIDTH(8), .RESET_VALUE(64'h5A)) u_d8 (
        .MainClock (clk),
        .MainReset (rst_n),
        .load      (ld),
        .d         (dv),
        .q         (q8),
        .qn        (qn8)
    );

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of inputs mid-cycle and queue the value expected after the next edge.
    task automatic step(input logic r, input logic l, input logic [7:0] d);
        @(negedge clk);
        rst_n = r;
        ld    = l;
        dv    = d;
        if (!r) begin
            m4 = 4'h0;
            m8 = 8'h5A;
        end else if (l) begin
            m4 = d[3:0];
            m8 = d;
        end
        sb.push_back('{m4, m8});
    endtask

    // Monitor: the register presents a result every edge; compare just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                check("q4",      {4'h0, q4},  {4'h0, cur.e4});
                check("qn4",     {4'h0, qn4}, {4'h0, ~cur.e4});
                check("q8",      q8,          cur.e8);
                check("qn8",     qn8,         ~cur.e8);
                check("qn4_inv", {4'h0, qn4}, {4'h0, ~q4});
                check("qn8_inv", qn8,         ~q8);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        ld    = 1'b0;
        dv    = 8'h00;
        m4    = 4'h0;
        m8    = 8'h00;

        // Reset wins over a simultaneous load.
        step(1'b0, 1'b1, 8'hFF);
        // Back-to-back loads.
        step(1'b1, 1'b1, 8'hAA);
        step(1'b1, 1'b1, 8'h33);
        // Hold while d sweeps all nibble values.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i * 17));
        end
        // Reset dropped mid-cycle has no effect before the edge.
        step(1'b0, 1'b0, 8'h77);
        #1;
        check("mid_rst_q4", {4'h0, q4}, 8'h03);
        check("mid_rst_q8", q8,         8'h33);
        // Release with load: first load on the first edge out of reset.
        step(1'b1, 1'b1, 8'h99);
        step(1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
